// File: rtl/ex_pkg.sv
// Shared execute-stage definitions: op classes, forward selects and slot records.
// Used by the hazard unit, the decoder and ALU control.
package ex_pkg;

  localparam logic [2:0] OP_R      = 3'd0;
  localparam logic [2:0] OP_I      = 3'd1;
  localparam logic [2:0] OP_LOAD   = 3'd2;
  localparam logic [2:0] OP_STORE  = 3'd3;
  localparam logic [2:0] OP_BRANCH = 3'd4;

  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_MEM = 2'd1;
  localparam logic [1:0] FWD_WB  = 2'd2;

  typedef struct packed {
    logic [4:0] rsd;
    logic       wen;
    logic       is_load;
  } mem_slot_t;

  typedef struct packed {
    logic [4:0] rsd;
    logic       wen;
  } wb_slot_t;

  function automatic logic writes_rd(input logic [2:0] op);
    return (op == OP_R) || (op == OP_I) || (op == OP_LOAD);
  endfunction

endpackage

// File: rtl/fwd_sel.sv
// Operand forwarding mux for one ALU source: MEM beats WB beats register file.
// x0 never forwards, and a load sitting in MEM has no data yet so it is skipped.
module fwd_sel
  import ex_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [4:0]      src_i,
  input  logic [XLEN-1:0] rf_data_i,
  input  mem_slot_t       mem_slot_i,
  input  logic [XLEN-1:0] mem_result_i,
  input  wb_slot_t        wb_slot_i,
  input  logic [XLEN-1:0] wb_result_i,
  output logic [XLEN-1:0] op_o,
  output logic [1:0]      fwd_o
);

  logic w_src_nz;
  logic w_mem_hit;
  logic w_wb_hit;

  assign w_src_nz  = (src_i != 5'd0);
  assign w_mem_hit = w_src_nz && mem_slot_i.wen && !mem_slot_i.is_load &&
                     (mem_slot_i.rsd == src_i);
  assign w_wb_hit  = w_src_nz && wb_slot_i.wen && (wb_slot_i.rsd == src_i);

  always_comb begin
    fwd_o = FWD_RF;
    op_o  = rf_data_i;
    if (w_mem_hit) begin
      fwd_o = FWD_MEM;
      op_o  = mem_result_i;
    end else if (w_wb_hit) begin
      fwd_o = FWD_WB;
      op_o  = wb_result_i;
    end
  end

endmodule

// File: rtl/ex_hazard_unit.sv
// Execute-stage hazard unit: tracks MEM/WB destinations, forwards ALU operands,
// and raises a one-cycle stall plus bubble on a load-use dependency.
module ex_hazard_unit
  import ex_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       id_rs1_i,
  input  logic [4:0]       id_rs2_i,
  input  logic             id_uses_rs2_i,
  input  logic [4:0]       ex_rs1_i,
  input  logic [4:0]       ex_rs2_i,
  input  logic [4:0]       ex_rsd_i,
  input  logic [2:0]       ex_Op_i,
  input  logic             ex_valid_i,
  input  logic [XLEN-1:0]  ex_rs1_data_i,
  input  logic [XLEN-1:0]  ex_rs2_data_i,
  input  logic [XLEN-1:0]  mem_result_i,
  input  logic [XLEN-1:0]  wb_result_i,
  output logic [XLEN-1:0]  op_a_o,
  output logic [XLEN-1:0]  op_b_o,
  output logic [1:0]       fwd_a_o,
  output logic [1:0]       fwd_b_o,
  output logic             stall_o,
  output logic             bubble_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  mem_slot_t        r_mem;
  wb_slot_t         r_wb;
  logic [CNT_W-1:0] r_stall_cnt;
  logic             w_load_use;
  logic             w_id_hit;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_mem <= '0;
      r_wb  <= '0;
    end else begin
      r_mem.rsd     <= ex_rsd_i;
      r_mem.wen     <= ex_valid_i && writes_rd(ex_Op_i);
      r_mem.is_load <= (ex_Op_i == OP_LOAD);
      r_wb.rsd      <= r_mem.rsd;
      r_wb.wen      <= r_mem.wen;
    end
  end

  // Gated by rst_i so the stall drops the instant reset is asserted.
  assign w_id_hit   = (ex_rsd_i == id_rs1_i) || (id_uses_rs2_i && (ex_rsd_i == id_rs2_i));
  assign w_load_use = rst_i && ex_valid_i && (ex_Op_i == OP_LOAD) &&
                      (ex_rsd_i != 5'd0) && w_id_hit;

  assign stall_o  = w_load_use;
  assign bubble_o = w_load_use;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_stall_cnt <= '0;
    end else if (w_load_use && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign stall_cnt_o = r_stall_cnt;

  fwd_sel #(.XLEN(XLEN)) u_fwd_a (
    .src_i        (ex_rs1_i),
    .rf_data_i    (ex_rs1_data_i),
    .mem_slot_i   (r_mem),
    .mem_result_i (mem_result_i),
    .wb_slot_i    (r_wb),
    .wb_result_i  (wb_result_i),
    .op_o         (op_a_o),
    .fwd_o        (fwd_a_o)
  );

  fwd_sel #(.XLEN(XLEN)) u_fwd_b (
    .src_i        (ex_rs2_i),
    .rf_data_i    (ex_rs2_data_i),
    .mem_slot_i   (r_mem),
    .mem_result_i (mem_result_i),
    .wb_slot_i    (r_wb),
    .wb_result_i  (wb_result_i),
    .op_o         (op_b_o),
    .fwd_o        (fwd_b_o)
  );

endmodule

// File: tb/tb_ex_hazard_unit.sv
// Scenario bench for ex_hazard_unit: expectations are queued as stimulus is driven,
// observations are captured mid-cycle, and each scenario compares its own queue.
module tb_ex_hazard_unit;
  import ex_pkg::*;

  localparam int XLEN  = 32;
  localparam int CNT_W = 4;
  localparam int VW    = 6 + 2 * XLEN + CNT_W;

  localparam logic [XLEN-1:0] RF_A  = 32'hAAAA_0001;
  localparam logic [XLEN-1:0] RF_B  = 32'hBBBB_0002;
  localparam logic [XLEN-1:0] MEM_R = 32'h0000_1234;
  localparam logic [XLEN-1:0] WB_R  = 32'h0000_5678;

  logic             clk_i, rst_i;
  logic [4:0]       id_rs1_i, id_rs2_i;
  logic             id_uses_rs2_i;
  logic [4:0]       ex_rs1_i, ex_rs2_i, ex_rsd_i;
  logic [2:0]       ex_Op_i;
  logic             ex_valid_i;
  logic [XLEN-1:0]  ex_rs1_data_i, ex_rs2_data_i, mem_result_i, wb_result_i;
  logic [XLEN-1:0]  op_a_o, op_b_o;
  logic [1:0]       fwd_a_o, fwd_b_o;
  logic             stall_o, bubble_o;
  logic [CNT_W-1:0] stall_cnt_o;

  ex_hazard_unit #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .id_rs1_i      (id_rs1_i),
    .id_rs2_i      (id_rs2_i),
    .id_uses_rs2_i (id_uses_rs2_i),
    .ex_rs1_i      (ex_rs1_i),
    .ex_rs2_i      (ex_rs2_i),
    .ex_rsd_i      (ex_rsd_i),
    .ex_Op_i       (ex_Op_i),
    .ex_valid_i    (ex_valid_i),
    .ex_rs1_data_i (ex_rs1_data_i),
    .ex_rs2_data_i (ex_rs2_data_i),
    .mem_result_i  (mem_result_i),
    .wb_result_i   (wb_result_i),
    .op_a_o        (op_a_o),
    .op_b_o        (op_b_o),
    .fwd_a_o       (fwd_a_o),
    .fwd_b_o       (fwd_b_o),
    .stall_o       (stall_o),
    .bubble_o      (bubble_o),
    .stall_cnt_o   (stall_cnt_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    string          name;
    logic [VW-1:0]  val;
  } exp_t;

  exp_t             sb[$];
  logic [VW-1:0]    got[$];
  int               errors = 0;
  int               checks = 0;
  logic [CNT_W-1:0] exp_cnt;
  logic             exp_stall;

  function automatic logic [XLEN-1:0] sel(input logic [1:0] f, input logic [XLEN-1:0] rf);
    if (f == 2'd1) return MEM_R;
    if (f == 2'd2) return WB_R;
    return rf;
  endfunction

  task automatic ex(input logic v, input logic [2:0] op, input logic [4:0] rsd,
                    input logic [4:0] rs1, input logic [4:0] rs2);
    ex_valid_i = v; ex_Op_i = op; ex_rsd_i = rsd; ex_rs1_i = rs1; ex_rs2_i = rs2;
  endtask

  task automatic id(input logic [4:0] rs1, input logic [4:0] rs2, input logic uses);
    id_rs1_i = rs1; id_rs2_i = rs2; id_uses_rs2_i = uses;
  endtask

  // Bench-side counter model advances on each edge where a stall was expected.
  task automatic tick();
    @(posedge clk_i);
    if (exp_stall && exp_cnt != {CNT_W{1'b1}}) exp_cnt = exp_cnt + 1'b1;
    #1;
  endtask

  // Queue the expected outputs, let inputs settle, then capture the DUT outputs.
  task automatic step(input string name, input logic st, input logic [1:0] fa,
                      input logic [1:0] fb);
    exp_t e;
    exp_stall = st;
    e.name = name;
    e.val  = {st, st, fa, fb, sel(fa, RF_A), sel(fb, RF_B), exp_cnt};
    sb.push_back(e);
    #2;
    got.push_back({stall_o, bubble_o, fwd_a_o, fwd_b_o, op_a_o, op_b_o, stall_cnt_o});
  endtask

  task automatic flush();
    ex(1'b0, OP_R, 5'd0, 5'd0, 5'd0);
    id(5'd0, 5'd0, 1'b0);
    exp_stall = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    exp_t e; logic [VW-1:0] g;
    rst_i = 1'b0;
    exp_cnt = '0;
    ex(1'b1, OP_LOAD, 5'd9, 5'd9, 5'd9);
    id(5'd9, 5'd9, 1'b1);
    #3;
    step("rst_hold", 1'b0, 2'd0, 2'd0);
    tick();
    tick();
    step("rst_hold_clk", 1'b0, 2'd0, 2'd0);
    ex(1'b0, OP_R, 5'd0, 5'd0, 5'd0);
    rst_i = 1'b1;
    step("rst_release", 1'b0, 2'd0, 2'd0);
    while (sb.size() > 0) begin
      e = sb.pop_front(); g = got.pop_front(); checks++;
      if (g !== e.val) begin
        errors++;
        $display("FAIL %s got=%h exp=%h", e.name, g, e.val);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e; logic [VW-1:0] g;
    flush();
    ex(1'b1, OP_R, 5'd5, 5'd10, 5'd11);
    id(5'd1, 5'd2, 1'b1);
    step("b2b_prod", 1'b0, 2'd0, 2'd0);
    tick();
    ex(1'b1, OP_R, 5'd8, 5'd5, 5'd6);
    step("b2b_cons", 1'b0, 2'd1, 2'd0);
    while (sb.size() > 0) begin
      e = sb.pop_front(); g = got.pop_front(); checks++;
      if (g !== e.val) begin
        errors++;
        $display("FAIL %s got=%h exp=%h", e.name, g, e.val);
      end
    end
  endtask

  task automatic test_distance2();
    exp_t e; logic [VW-1:0] g;
    flush();
    ex(1'b1, OP_I, 5'd7, 5'd1, 5'd0);
    step("d2_prod", 1'b0, 2'd0, 2'd0);
    tick();
    ex(1'b1, OP_I, 5'd4, 5'd1, 5'd0);
    step("d2_mid", 1'b0, 2'd0, 2'd0);
    tick();
    ex(1'b1, OP_R, 5'd12, 5'd2, 5'd7);
    step("d2_cons", 1'b0, 2'd0, 2'd2);
    while (sb.size() > 0) begin
      e = sb.pop_front(); g = got.pop_front(); checks++;
      if (g !== e.val) begin
        errors++;
        $display("FAIL %s got=%h exp=%h", e.name, g, e.val);
      end
    end
  endtask

  task automatic test_double_match();
    exp_t e; logic [VW-1:0] g;
    flush();
    ex(1'b1, OP_I, 5'd3, 5'd0, 5'd0);
    tick();
    ex(1'b1, OP_R, 5'd3, 5'd0, 5'd0);
    step("dbl_mid", 1'b0, 2'd0, 2'd0);
    tick();
    ex(1'b1, OP_R, 5'd13, 5'd3, 5'd3);
    step("dbl_both", 1'b0, 2'd1, 2'd1);
    tick();
    ex(1'b1, OP_R, 5'd14, 5'd3, 5'd3);
    step("dbl_wb_only", 1'b0, 2'd2, 2'd2);
    while (sb.size() > 0) begin
      e = sb.pop_front(); g = got.pop_front(); checks++;
      if (g !== e.val) begin
        errors++;
        $display("FAIL %s got=%h exp=%h", e.name, g, e.val);
      end
    end
  endtask

  task automatic test_x0();
    exp_t e; logic [VW-1:0] g;
    flush();
    ex(1'b1, OP_R, 5'd0, 5'd0, 5'd0);
    id(5'd0, 5'd0, 1'b1);
    step("x0_prod", 1'b0, 2'd0, 2'd0);
    tick();
    ex(1'b1, OP_LOAD, 5'd0, 5'd0, 5'd0);
    step("x0_load_nostall", 1'b0, 2'd0, 2'd0);
    tick();
    ex(1'b1, OP_R, 5'd1, 5'd0, 5'd0);
    step("x0_cons", 1'b0, 2'd0, 2'd0);
    while (sb.size() > 0) begin
      e = sb.pop_front(); g = got.pop_front(); checks++;
      if (g !== e.val) begin
        errors++;
        $display("FAIL %s got=%h exp=%h", e.name, g, e.val);
      end
    end
  endtask

  task automatic test_nonwriters();
    exp_t e; logic [VW-1:0] g;
    flush();
    ex(1'b1, OP_STORE, 5'd5, 5'd0, 5'd0);
    tick();
    ex(1'b1, OP_BRANCH, 5'd6, 5'd0, 5'd0);
    tick();
    ex(1'b0, OP_R, 5'd7, 5'd5, 5'd6);
    step("nw_store_branch", 1'b0, 2'd0, 2'd0);
    tick();
    ex(1'b1, OP_R, 5'd1, 5'd7, 5'd5);
    step("nw_bubble", 1'b0, 2'd0, 2'd0);
    while (sb.size() > 0) begin
      e = sb.pop_front(); g = got.pop_front(); checks++;
      if (g !== e.val) begin
        errors++;
        $display("FAIL %s got=%h exp=%h", e.name, g, e.val);
      end
    end
  endtask

  task automatic test_load_use();
    exp_t e; logic [VW-1:0] g;
    flush();
    ex(1'b1, OP_LOAD, 5'd9, 5'd1, 5'd0);
    id(5'd9, 5'd2, 1'b1);
    step("lu_stall", 1'b1, 2'd0, 2'd0);
    tick();
    ex(1'b0, OP_R, 5'd0, 5'd9, 5'd0);
    step("lu_release", 1'b0, 2'd0, 2'd0);
    tick();
    ex(1'b1, OP_R, 5'd10, 5'd9, 5'd2);
    id(5'd0, 5'd0, 1'b0);
    step("lu_wb_fwd", 1'b0, 2'd2, 2'd0);
    while (sb.size() > 0) begin
      e = sb.pop_front(); g = got.pop_front(); checks++;
      if (g !== e.val) begin
        errors++;
        $display("FAIL %s got=%h exp=%h", e.name, g, e.val);
      end
    end
  endtask

  task automatic test_rs2_gate();
    exp_t e; logic [VW-1:0] g;
    flush();
    ex(1'b1, OP_LOAD, 5'd9, 5'd0, 5'd0);
    id(5'd1, 5'd9, 1'b0);
    step("rs2_unused", 1'b0, 2'd0, 2'd0);
    id(5'd1, 5'd9, 1'b1);
    step("rs2_used", 1'b1, 2'd0, 2'd0);
    id(5'd8, 5'd10, 1'b1);
    step("rs_other", 1'b0, 2'd0, 2'd0);
    ex(1'b0, OP_LOAD, 5'd9, 5'd0, 5'd0);
    id(5'd9, 5'd9, 1'b1);
    step("load_invalid", 1'b0, 2'd0, 2'd0);
    while (sb.size() > 0) begin
      e = sb.pop_front(); g = got.pop_front(); checks++;
      if (g !== e.val) begin
        errors++;
        $display("FAIL %s got=%h exp=%h", e.name, g, e.val);
      end
    end
  endtask

  task automatic test_saturate();
    exp_t e; logic [VW-1:0] g;
    flush();
    ex(1'b1, OP_LOAD, 5'd9, 5'd0, 5'd0);
    id(5'd9, 5'd0, 1'b0);
    step("sat_begin", 1'b1, 2'd0, 2'd0);
    for (int i = 0; i < 20; i++) tick();
    step("sat_hold", 1'b1, 2'd0, 2'd0);
    ex(1'b0, OP_R, 5'd0, 5'd0, 5'd0);
    step("sat_idle", 1'b0, 2'd0, 2'd0);
    while (sb.size() > 0) begin
      e = sb.pop_front(); g = got.pop_front(); checks++;
      if (g !== e.val) begin
        errors++;
        $display("FAIL %s got=%h exp=%h", e.name, g, e.val);
      end
    end
  endtask

  task automatic test_reset_mid_stall();
    exp_t e; logic [VW-1:0] g;
    flush();
    ex(1'b1, OP_R, 5'd5, 5'd0, 5'd0);
    step("rms_prod", 1'b0, 2'd0, 2'd0);
    tick();
    ex(1'b1, OP_LOAD, 5'd9, 5'd5, 5'd0);
    id(5'd9, 5'd0, 1'b0);
    step("rms_stall", 1'b1, 2'd1, 2'd0);
    #1;
    rst_i = 1'b0;
    exp_cnt = '0;
    step("rms_async_clear", 1'b0, 2'd0, 2'd0);
    ex(1'b0, OP_R, 5'd0, 5'd5, 5'd0);
    rst_i = 1'b1;
    step("rms_release", 1'b0, 2'd0, 2'd0);
    tick();
    ex(1'b1, OP_R, 5'd6, 5'd5, 5'd0);
    step("rms_no_fwd", 1'b0, 2'd0, 2'd0);
    while (sb.size() > 0) begin
      e = sb.pop_front(); g = got.pop_front(); checks++;
      if (g !== e.val) begin
        errors++;
        $display("FAIL %s got=%h exp=%h", e.name, g, e.val);
      end
    end
  endtask

  initial begin
    exp_stall     = 1'b0;
    exp_cnt       = '0;
    ex_rs1_data_i = RF_A;
    ex_rs2_data_i = RF_B;
    mem_result_i  = MEM_R;
    wb_result_i   = WB_R;
    test_reset();
    test_back_to_back();
    test_distance2();
    test_double_match();
    test_x0();
    test_nonwriters();
    test_load_use();
    test_rs2_gate();
    test_saturate();
    test_reset_mid_stall();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
